// File: rtl/expmu_table_buffer_pkg.sv
// Shared constants and state encoding for the S0*exp(t*mu) ping-pong table.
// Defaults match the production drift-stage window.
package expmu_table_buffer_pkg;

    localparam int EXPMU_T_MIN = 343;
    localparam int EXPMU_T_MAX = 511;
    localparam int EXPMU_LOGT  = 9;
    localparam int EXPMU_DW    = 18;
    localparam int EXPMU_T_LEN = EXPMU_T_MAX - EXPMU_T_MIN + 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FILL      = 2'd1;
    localparam logic [1:0] ST_SWAP_WAIT = 2'd2;

    function automatic logic in_window(
        input int t,
        input int lo,
        input int hi
    );
        return (t >= lo) && (t <= hi);
    endfunction

endpackage

// File: rtl/expmu_bank_ram.sv
// Two-bank table storage: one write port, one registered read port.
// The address MSB selects the bank.
module expmu_bank_ram #(
    parameter int AW = 10,
    parameter int DW = 18
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/expmu_table_buffer.sv
// Ping-pong buffer for the streamed (t, S0*exp(t*mu)) drift table.
// Swaps banks only after a complete, in-order fill.
module expmu_table_buffer
    import expmu_table_buffer_pkg::*;
#(
    parameter int T_MIN = EXPMU_T_MIN,
    parameter int T_MAX = EXPMU_T_MAX,
    parameter int LOGT  = EXPMU_LOGT,
    parameter int DW    = EXPMU_DW
) (
    input  logic            CLK,
    input  logic            iRst_n,
    input  logic            iStart,
    input  logic            iValid,
    input  logic [LOGT-1:0] iAddr,
    input  logic [DW-1:0]   iData,
    input  logic            iDone,
    input  logic            iRdBusy,
    input  logic [LOGT-1:0] iRdAddr,
    output logic [DW-1:0]   oRdData,
    output logic            oTableValid,
    output logic            oFilling,
    output logic            oSwap,
    output logic            oErr
);

    localparam logic [LOGT:0] BASE     = (LOGT+1)'(T_MIN);
    localparam logic [LOGT:0] CNT_FULL = (LOGT+1)'(T_MAX - T_MIN + 1);

    logic [1:0]    state;
    logic          wr_sel;
    logic [LOGT:0] count;
    logic [LOGT:0] exp_addr;
    logic [LOGT:0] cnt_nxt;
    logic          in_fill;
    logic          accept;
    logic          bad_wr;
    logic          done_ok;
    logic          rd_ok;
    logic [DW-1:0] ram_q;

    assign in_fill  = (state == ST_FILL) && !iStart;
    assign exp_addr = BASE + count;

    // count == CNT_FULL blocks any further write, even one at T_MAX.
    assign accept = in_fill && iValid
                 && (count != CNT_FULL)
                 && ({1'b0, iAddr} == exp_addr);
    assign bad_wr = in_fill && iValid && !accept;

    assign cnt_nxt = count + {{LOGT{1'b0}}, accept};
    assign done_ok = (cnt_nxt == CNT_FULL) && !oErr && !bad_wr;

    assign oFilling = (state == ST_FILL);

    always_ff @(posedge CLK or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= ST_IDLE;
            wr_sel      <= 1'b0;
            count       <= '0;
            oTableValid <= 1'b0;
            oSwap       <= 1'b0;
            oErr        <= 1'b0;
            rd_ok       <= 1'b0;
        end else begin
            oSwap <= 1'b0;
            rd_ok <= oTableValid
                  && in_window(int'(iRdAddr), T_MIN, T_MAX);
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        state <= ST_FILL;
                        count <= '0;
                        oErr  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (iStart) begin
                        count <= '0;
                        oErr  <= 1'b0;
                    end else begin
                        count <= cnt_nxt;
                        if (bad_wr) begin
                            oErr <= 1'b1;
                        end
                        if (iDone) begin
                            if (done_ok) begin
                                state <= ST_SWAP_WAIT;
                            end else begin
                                oErr  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_SWAP_WAIT: begin
                    if (!iRdBusy) begin
                        wr_sel      <= ~wr_sel;
                        oSwap       <= 1'b1;
                        oTableValid <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read bank is always the complement of the fill bank.
    expmu_bank_ram #(
        .AW (LOGT + 1),
        .DW (DW)
    ) u_ram (
        .CLK   (CLK),
        .we    (accept),
        .waddr ({wr_sel, iAddr}),
        .wdata (iData),
        .raddr ({~wr_sel, iRdAddr}),
        .rdata (ram_q)
    );

    assign oRdData = rd_ok ? ram_q : '0;

endmodule

// File: tb/tb_expmu_table_buffer.sv
// Randomized bench for expmu_table_buffer against a table-level model.
// The model tracks the last completed table and the table being filled.
module tb_expmu_table_buffer;
    import expmu_table_buffer_pkg::*;

    localparam int TMIN = EXPMU_T_MIN;
    localparam int TMAX = EXPMU_T_MAX;
    localparam int LW   = EXPMU_LOGT;
    localparam int W    = EXPMU_DW;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_WAIT = 2;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          start, valid, done, busy;
    logic [LW-1:0] addr, rd_addr;
    logic [W-1:0]  data;
    logic [W-1:0]  rd_data;
    logic          tvalid, filling, swap, err;

    int checks   = 0;
    int failures = 0;
    bit hold_rd;

    int         m_mode;
    int         m_next;
    bit         m_err, m_tv, m_swap;
    logic [W-1:0] m_fill [0:(1<<LW)-1];
    logic [W-1:0] m_rd   [0:(1<<LW)-1];

    expmu_table_buffer dut (
        .CLK         (CLK),
        .iRst_n      (rst_n),
        .iStart      (start),
        .iValid      (valid),
        .iAddr       (addr),
        .iData       (data),
        .iDone       (done),
        .iRdBusy     (busy),
        .iRdAddr     (rd_addr),
        .oRdData     (rd_data),
        .oTableValid (tvalid),
        .oFilling    (filling),
        .oSwap       (swap),
        .oErr        (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    // One clock: predict from current inputs, clock, then compare.
    task automatic step();
        logic [W-1:0] e_rd;
        int           ra;
        if (!hold_rd) begin
            rd_addr = LW'($urandom_range(TMIN - 10, (1 << LW) - 1));
        end
        ra     = int'(rd_addr);
        e_rd   = (m_tv && ra >= TMIN && ra <= TMAX) ? m_rd[ra] : '0;
        m_swap = 1'b0;
        if (m_mode == M_IDLE) begin
            if (start) begin
                m_mode = M_FILL;
                m_next = TMIN;
                m_err  = 1'b0;
            end
        end else if (m_mode == M_FILL) begin
            if (start) begin
                m_next = TMIN;
                m_err  = 1'b0;
            end else begin
                if (valid) begin
                    if (int'(addr) == m_next && m_next <= TMAX) begin
                        m_fill[addr] = data;
                        m_next++;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (done) begin
                    if (m_next == TMAX + 1 && !m_err) begin
                        m_mode = M_WAIT;
                    end else begin
                        m_err  = 1'b1;
                        m_mode = M_IDLE;
                    end
                end
            end
        end else begin
            if (!busy) begin
                m_rd   = m_fill;
                m_swap = 1'b1;
                m_tv   = 1'b1;
                m_mode = M_IDLE;
            end
        end
        @(posedge CLK);
        #1;
        chk("swap", 32'(swap), 32'(m_swap));
        chk("tvalid", 32'(tvalid), 32'(m_tv));
        chk("filling", 32'(filling), 32'(m_mode == M_FILL));
        chk("err", 32'(err), 32'(m_err));
        chk("rdata", 32'(rd_data), 32'(e_rd));
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        valid = 1'b0;
        done  = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    // mode 0: t*4, 1: t, 2: random data
    task automatic run_fill(input int mode, input int skip_t,
                            input int last_t, input bit done_last,
                            input bit busy_done);
        start = 1'b1;
        step();
        start = 1'b0;
        busy  = 1'b0;
        for (int t = TMIN; t <= last_t; t++) begin
            if (t == skip_t) begin
                continue;
            end
            if ($urandom_range(0, 5) == 0) begin
                valid = 1'b0;
                step();
            end
            valid = 1'b1;
            addr  = LW'(t);
            case (mode)
                0:       data = W'(t * 4);
                1:       data = W'(t);
                default: data = W'($urandom_range(0, (1 << W) - 1));
            endcase
            done = done_last && (t == last_t);
            if (done) begin
                busy = busy_done;
            end
            step();
        end
        valid = 1'b0;
        if (!done_last) begin
            done = 1'b1;
            busy = busy_done;
            step();
        end
        done = 1'b0;
    endtask

    task automatic read_at(input int a, input logic [W-1:0] exp,
                           input string tag);
        hold_rd = 1'b1;
        rd_addr = LW'(a);
        step();
        idle(1);
        hold_rd = 1'b0;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        valid   = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;
        addr    = '0;
        data    = '0;
        rd_addr = '0;
        hold_rd = 1'b0;
        m_mode  = M_IDLE;
        m_next  = TMIN;
        m_err   = 1'b0;
        m_tv    = 1'b0;
        m_swap  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rdata", 32'(rd_data), 0);
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_filling", 32'(filling), 0);
        chk("rst_swap", 32'(swap), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        // basic fill, data = t*4
        run_fill(0, -1, TMAX, 1'b0, 1'b0);
        idle(1);
        chk("basic_swapped", 32'(tvalid), 1);
        read_at(343, 18'h0055C, "rd343");
        read_at(511, 18'h007FC, "rd511");
        read_at(342, 18'h0, "rd342");

        // swap hold-off, data = t
        run_fill(1, -1, TMAX, 1'b0, 1'b1);
        hold_rd = 1'b1;
        rd_addr = LW'(400);
        idle(5);
        chk("hold_old", 32'(rd_data), 32'(400 * 4));
        busy = 1'b0;
        idle(1);
        chk("hold_swap", 32'(swap), 1);
        idle(2);
        chk("hold_new", 32'(rd_data), 400);
        hold_rd = 1'b0;

        // out-of-order: skip t=400
        run_fill(2, 400, TMAX, 1'b0, 1'b0);
        idle(4);
        chk("ooo_err", 32'(err), 1);
        read_at(450, W'(450), "ooo_old");

        // short stream
        run_fill(2, -1, 500, 1'b0, 1'b0);
        idle(3);
        chk("short_err", 32'(err), 1);

        // last write coincident with done
        run_fill(2, -1, TMAX, 1'b1, 1'b0);
        idle(1);
        chk("simul_swap", 32'(swap), 1);
        idle(3);

        // reset mid-fill
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = TMIN; t <= 420; t++) begin
            valid = 1'b1;
            addr  = LW'(t);
            data  = W'($urandom_range(0, (1 << W) - 1));
            step();
        end
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_rdata", 32'(rd_data), 0);
        chk("mrst_tvalid", 32'(tvalid), 0);
        chk("mrst_filling", 32'(filling), 0);
        chk("mrst_err", 32'(err), 0);
        m_mode = M_IDLE;
        m_err  = 1'b0;
        m_tv   = 1'b0;
        m_swap = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        idle(20);
        run_fill(2, -1, TMAX, 1'b0, 1'b0);
        idle(20);

        // randomized fills
        for (int k = 0; k < 6; k++) begin
            int  sk, lt;
            bit  dl, bd;
            sk = ($urandom_range(0, 3) == 0)
               ? int'($urandom_range(TMIN, TMAX)) : -1;
            lt = ($urandom_range(0, 4) == 0)
               ? int'($urandom_range(TMIN, TMAX)) : TMAX;
            dl = 1'($urandom_range(0, 1));
            bd = 1'($urandom_range(0, 1));
            run_fill(2, sk, lt, dl, bd);
            idle(int'($urandom_range(0, 6)));
            busy = 1'b0;
            idle(10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
